// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int WAIT_W      = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard/memory inputs and pipeline control outputs
interface pipeline_stall_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             hazard_i;
  logic             flush_i;
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             pc_write_o;
  logic             if_id_write_o;
  logic             if_id_flush_o;
  logic             id_ex_bubble_o;
  logic             pipe_hold_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output hazard_i, flush_i, mem_req_i, mem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    input  pipe_hold_o, err_o, stall_cnt_o
  );

  modport slave (
    input  hazard_i, flush_i, mem_req_i, mem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    output pipe_hold_o, err_o, stall_cnt_o
  );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// rtl/pipeline_stall_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - RUN/MEM_WAIT/ERROR stall, bubble and flush control
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              err_q, err_d;
  logic              mem_stall, stall_hold, run_eval;
  logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
  logic [CNT_W-1:0]  stall_cnt;

  assign mem_stall = bus.mem_req_i & ~bus.mem_ack_i;
  assign wait_inc  = wait_q + WAIT_W'(1);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    stall_hold   = 1'b0;
    run_eval     = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          stall_hold = 1'b1;
          state_d    = ST_MEM_WAIT;
          // The request cycle itself is the first wait cycle.
          wait_d     = WAIT_W'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ack_i) begin
          run_eval = 1'b1;
          state_d  = ST_RUN;
          wait_d   = '0;
        end else begin
          stall_hold = 1'b1;
          wait_d     = wait_inc;
          if (wait_inc >= TIMEOUT_W) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        stall_hold = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase

    // Memory stall outranks hazard, and hazard outranks flush.
    if (stall_hold) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (run_eval && bus.hazard_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (run_eval && bus.flush_i) begin
      if_id_flush = 1'b1;
    end

    if (!rst_i) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
    end
  end

  assign err_d = err_q | (state_d == ST_ERROR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (~pc_write),
    .clear (1'b0),
    .count (stall_cnt)
  );

  assign bus.pc_write_o     = pc_write;
  assign bus.if_id_write_o  = if_id_write;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_bubble_o = id_ex_bubble;
  assign bus.pipe_hold_o    = pipe_hold;
  assign bus.err_o          = err_q;
  assign bus.stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl with TIMEOUT=4
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    string            name;
    logic [4:0]       ctrl;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i;
  logic exp_vld;
  int   n_checks;
  int   n_fails;
  exp_t sb_q[$];

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  pipeline_stall_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // ctrl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  task automatic step(input string name, input logic r, input logic h, input logic f,
                      input logic q, input logic a, input logic chk,
                      input logic [4:0] ctrl, input logic err, input logic [CNT_W-1:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_i            = r;
    bus_if.hazard_i  = h;
    bus_if.flush_i   = f;
    bus_if.mem_req_i = q;
    bus_if.mem_ack_i = a;
    exp_vld          = chk;
    if (chk) begin
      e.name = name;
      e.ctrl = ctrl;
      e.err  = err;
      e.cnt  = cnt;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [4:0] act;
    if (exp_vld) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard_underflow: output presented with no expectation queued");
      end else begin
        e   = sb_q.pop_front();
        act = {bus_if.pc_write_o, bus_if.if_id_write_o, bus_if.if_id_flush_o,
               bus_if.id_ex_bubble_o, bus_if.pipe_hold_o};
        n_checks++;
        if (act !== e.ctrl) begin
          n_fails++;
          $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
        end
        n_checks++;
        if (bus_if.err_o !== e.err) begin
          n_fails++;
          $display("FAIL %s err_o: got %b expected %b", e.name, bus_if.err_o, e.err);
        end
        n_checks++;
        if (bus_if.stall_cnt_o !== e.cnt) begin
          n_fails++;
          $display("FAIL %s stall_cnt_o: got %0d expected %0d", e.name, bus_if.stall_cnt_o, e.cnt);
        end
      end
    end
  end

  initial begin
    n_checks         = 0;
    n_fails          = 0;
    exp_vld          = 1'b0;
    rst_i            = 1'b0;
    bus_if.hazard_i  = 1'b0;
    bus_if.flush_i   = 1'b0;
    bus_if.mem_req_i = 1'b0;
    bus_if.mem_ack_i = 1'b0;

    //     name                  rst haz fl  req ack chk ctrl      err cnt
    step("reset_defaults",      0,  1,  0,  0,  0,  1,  5'b11000, 0,  16'd0);
    step("run_idle",            1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd0);
    step("load_use",            1,  1,  0,  0,  0,  1,  5'b00010, 0,  16'd0);
    step("load_use_after",      1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd1);
    step("haz_and_flush",       1,  1,  1,  0,  0,  1,  5'b00010, 0,  16'd1);
    step("flush_only",          1,  0,  1,  0,  0,  1,  5'b11100, 0,  16'd2);
    step("same_ack_hazard",     1,  1,  0,  1,  1,  1,  5'b00010, 0,  16'd2);
    step("same_ack_nostall",    1,  0,  0,  1,  1,  1,  5'b11000, 0,  16'd3);
    step("mem_prio_cycle1",     1,  1,  1,  1,  0,  1,  5'b00001, 0,  16'd3);
    step("mem_wait_cycle2",     1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd4);
    step("mem_wait_cycle3",     1,  1,  0,  1,  0,  1,  5'b00001, 0,  16'd5);
    step("mem_ack_cycle4",      1,  0,  0,  1,  1,  1,  5'b11000, 0,  16'd6);
    step("after_ack_run",       1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd6);
    step("wait_then_flush_1",   1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd6);
    step("ack_with_flush",      1,  0,  1,  1,  1,  1,  5'b11100, 0,  16'd7);
    step("after_ack_flush",     1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd7);
    step("pre_reset_wait1",     1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd7);
    step("pre_reset_wait2",     1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd8);
    step("reset_mid_wait",      0,  0,  0,  1,  0,  1,  5'b11000, 0,  16'd0);
    step("post_reset_run",      1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd0);
    step("timeout_cycle1",      1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd0);
    step("timeout_cycle2",      1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd1);
    step("timeout_cycle3",      1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd2);
    step("timeout_cycle4",      1,  0,  0,  1,  0,  1,  5'b00001, 0,  16'd3);
    step("error_ignores_ack",   1,  1,  1,  1,  1,  1,  5'b00001, 1,  16'd4);
    step("error_sticky",        1,  0,  0,  0,  0,  1,  5'b00001, 1,  16'd5);

    for (int i = 0; i < 65540; i++) begin
      step("saturate", 1, 0, 0, 0, 0, 0, 5'b00000, 0, 16'd0);
    end

    step("sat_max",             1,  0,  0,  0,  0,  1,  5'b00001, 1,  16'hFFFF);
    step("sat_no_wrap",         1,  0,  0,  0,  0,  1,  5'b00001, 1,  16'hFFFF);
    step("reset_in_error",      0,  1,  0,  0,  0,  1,  5'b11000, 0,  16'd0);
    step("post_error_run",      1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd0);
    step("post_error_hazard",   1,  1,  0,  0,  0,  1,  5'b00010, 0,  16'd0);
    step("post_error_count",    1,  0,  0,  0,  0,  1,  5'b11000, 0,  16'd1);

    @(negedge clk);
    #1;
    exp_vld = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
